// File: rtl/pc_unit_pkg.sv
// Shared constants and state encoding for the program counter unit and the PC select mux.
package pc_unit_pkg;

  localparam int unsigned WIDTH_DEF    = 32;
  localparam int unsigned QW_DEF       = 16;
  localparam int unsigned OS_ENTRY_DEF = 524;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

endpackage

// File: rtl/pc_unit_quantum_counter.sv
// Instruction budget counter: load wins over decrement, and a zero count never moves.
module quantum_counter #(
  parameter int unsigned QW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [QW-1:0] value,
  input  logic          dec_en,
  output logic [QW-1:0] count,
  output logic          expire
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec_en && (count != '0)) begin
      count <= count - QW'(1);
    end
  end

  assign expire = (count == QW'(1));

endmodule

// File: rtl/pc_unit.sv
// Program counter register with stall, HALT and time-quantum preemption into the OS handler.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned OS_ENTRY = OS_ENTRY_DEF,
  parameter int unsigned QW       = QW_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_next,
  input  logic             stall,
  input  logic             halt,
  input  logic             resume,
  input  logic             quantum_load,
  input  logic [QW-1:0]    quantum,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus1,
  output logic [WIDTH-1:0] epc,
  output logic             trap,
  output logic             halted
);

  state_t        state;
  logic [QW-1:0] count;
  logic          expire;
  logic          retire;

  // A retirement is an unstalled, non-halt cycle in RUN; on expiry it takes the count 1 -> 0.
  assign retire = (state == ST_RUN) && !stall && !halt;

  quantum_counter #(
    .QW(QW)
  ) u_quantum_counter (
    .clock (clock),
    .reset (reset),
    .load  (quantum_load),
    .value (quantum),
    .dec_en(retire),
    .count (count),
    .expire(expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      pc    <= '0;
      epc   <= '0;
      trap  <= 1'b0;
      state <= ST_RUN;
    end else begin
      trap <= 1'b0;
      case (state)
        ST_RUN: begin
          if (stall) begin
            state <= ST_RUN;
          end else if (halt) begin
            state <= ST_HALTED;
          end else if (expire) begin
            epc  <= pc_next;
            pc   <= WIDTH'(OS_ENTRY);
            trap <= 1'b1;
          end else begin
            pc <= pc_next;
          end
        end
        ST_HALTED: begin
          if (resume) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign pc_plus1 = pc + WIDTH'(1);
  assign halted   = (state == ST_HALTED);

endmodule

// File: tb/tb_pc_unit.sv
// Randomized and directed checks of pc_unit against a budget-based behavioural model.
module tb_pc_unit;

  localparam int unsigned OS = 524;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_next;
  logic        stall, halt, resume, quantum_load;
  logic [15:0] quantum;
  logic [31:0] pc, pc_plus1, epc;
  logic        trap, halted;

  // Behavioural model: remaining budget as an integer, halted as a flag.
  logic [31:0] m_pc, m_epc;
  logic        m_trap, m_halted;
  int          m_budget;

  int total = 0;
  int bad   = 0;

  pc_unit dut (
    .clock       (clock),
    .reset       (reset),
    .pc_next     (pc_next),
    .stall       (stall),
    .halt        (halt),
    .resume      (resume),
    .quantum_load(quantum_load),
    .quantum     (quantum),
    .pc          (pc),
    .pc_plus1    (pc_plus1),
    .epc         (epc),
    .trap        (trap),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  task automatic tick();
    int nb;
    @(posedge clock);
    if (reset) begin
      m_pc = 0; m_epc = 0; m_trap = 0; m_halted = 0; m_budget = 0;
    end else begin
      nb = m_budget;
      m_trap = 0;
      if (!m_halted) begin
        if (stall) begin
        end else if (halt) begin
          m_halted = 1;
        end else if (m_budget == 1) begin
          m_epc = pc_next; m_pc = OS; m_trap = 1; nb = 0;
        end else begin
          m_pc = pc_next;
          if (nb > 0) nb = nb - 1;
        end
      end else if (resume) begin
        m_halted = 0;
      end
      if (quantum_load) nb = quantum;
      m_budget = nb;
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; halt = 0; resume = 0; quantum_load = 0; quantum = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 1; pc_next = 32'h1234;
    tick(); tick();
    reset = 0;
    total++; if (pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%0h want=0", pc); end
    total++; if (epc !== 32'd0) begin bad++; $display("FAIL reset_epc got=%0h want=0", epc); end
    total++; if (trap !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL reset_flags trap=%b halted=%b want=0 0", trap, halted); end
    total++; if (pc_plus1 !== 32'd1) begin bad++; $display("FAIL reset_pc_plus1 got=%0h want=1", pc_plus1); end
  endtask

  task automatic test_basic();
    idle_inputs(); pc_next = 5; tick();
    total++; if (pc !== 32'd5 || pc_plus1 !== 32'd6) begin bad++; $display("FAIL basic_pc got=%0h/%0h want=5/6", pc, pc_plus1); end
    pc_next = 32'hFFFF_FFFF; tick();
    total++; if (pc_plus1 !== 32'd0) begin bad++; $display("FAIL wrap_pc_plus1 got=%0h want=0", pc_plus1); end
    pc_next = OS; tick();
    total++; if (pc !== OS || trap !== 1'b0) begin bad++; $display("FAIL plain_os_entry pc=%0d trap=%b want=%0d 0", pc, trap, OS); end
  endtask

  task automatic test_quantum();
    idle_inputs(); stall = 1; quantum_load = 1; quantum = 3; tick();
    idle_inputs();
    pc_next = 10; tick();
    total++; if (pc !== 32'd10 || trap !== 1'b0) begin bad++; $display("FAIL quantum_r1 pc=%0d trap=%b want=10 0", pc, trap); end
    pc_next = 11; tick();
    total++; if (pc !== 32'd11 || trap !== 1'b0) begin bad++; $display("FAIL quantum_r2 pc=%0d trap=%b want=11 0", pc, trap); end
    pc_next = 12; tick();
    total++; if (pc !== OS || trap !== 1'b1 || epc !== 32'd12) begin bad++; $display("FAIL quantum_trap pc=%0d trap=%b epc=%0d want=%0d 1 12", pc, trap, epc, OS); end
    pc_next = 13; tick();
    total++; if (trap !== 1'b0 || pc !== 32'd13) begin bad++; $display("FAIL quantum_after trap=%b pc=%0d want=0 13", trap, pc); end
  endtask

  task automatic test_stall();
    int trap_at;
    idle_inputs(); stall = 1; quantum_load = 1; quantum = 3; tick();
    idle_inputs();
    trap_at = -1;
    for (int c = 1; c <= 12; c++) begin
      stall = (c >= 2 && c <= 5);
      pc_next = 32'd20 + c;
      tick();
      if (stall) begin
        total++; if (pc !== 32'd21) begin bad++; $display("FAIL stall_freeze cycle=%0d pc=%0d want=21", c, pc); end
      end
      if (trap === 1'b1 && trap_at < 0) trap_at = c;
    end
    stall = 0;
    total++; if (trap_at !== 7) begin bad++; $display("FAIL stall_trap_cycle got=%0d want=7", trap_at); end
    total++; if (epc !== 32'd27) begin bad++; $display("FAIL stall_epc got=%0d want=27", epc); end
  endtask

  task automatic test_halt();
    idle_inputs(); pc_next = 40; tick();
    halt = 1; pc_next = 99; tick();
    total++; if (halted !== 1'b1 || pc !== 32'd40) begin bad++; $display("FAIL halt_enter halted=%b pc=%0d want=1 40", halted, pc); end
    for (int i = 0; i < 3; i++) begin
      halt = i[0]; stall = i[1]; pc_next = $urandom; tick();
      total++; if (halted !== 1'b1 || pc !== 32'd40) begin bad++; $display("FAIL halt_hold halted=%b pc=%0d want=1 40", halted, pc); end
    end
    idle_inputs(); resume = 1; pc_next = 45; tick();
    total++; if (halted !== 1'b0 || pc !== 32'd40) begin bad++; $display("FAIL resume halted=%b pc=%0d want=0 40", halted, pc); end
    resume = 0; pc_next = 50; tick();
    total++; if (pc !== 32'd50) begin bad++; $display("FAIL resume_follow pc=%0d want=50", pc); end
  endtask

  task automatic test_halt_expiry();
    idle_inputs(); stall = 1; quantum_load = 1; quantum = 2; tick();
    idle_inputs(); pc_next = 60; tick();
    halt = 1; pc_next = 61; tick();
    total++; if (halted !== 1'b1 || trap !== 1'b0 || pc !== 32'd60) begin bad++; $display("FAIL halt_vs_expiry halted=%b trap=%b pc=%0d want=1 0 60", halted, trap, pc); end
    idle_inputs(); resume = 1; pc_next = 62; tick();
    total++; if (trap !== 1'b0 || pc !== 32'd60) begin bad++; $display("FAIL halt_expiry_resume trap=%b pc=%0d want=0 60", trap, pc); end
    resume = 0; pc_next = 70; tick();
    total++; if (trap !== 1'b1 || pc !== OS || epc !== 32'd70) begin bad++; $display("FAIL halt_expiry_trap trap=%b pc=%0d epc=%0d want=1 %0d 70", trap, pc, epc, OS); end
  endtask

  task automatic test_reset_halted();
    idle_inputs(); stall = 1; quantum_load = 1; quantum = 1; tick();
    idle_inputs(); pc_next = 77; tick();
    total++; if (epc !== 32'd77 || trap !== 1'b1) begin bad++; $display("FAIL setup_epc epc=%0d trap=%b want=77 1", epc, trap); end
    idle_inputs(); stall = 1; quantum_load = 1; quantum = 5; tick();
    idle_inputs(); halt = 1; tick();
    halt = 0; reset = 1; tick();
    reset = 0;
    total++; if (pc !== 32'd0 || epc !== 32'd0 || halted !== 1'b0 || trap !== 1'b0) begin bad++; $display("FAIL reset_halted pc=%0d epc=%0d halted=%b trap=%b want=0 0 0 0", pc, epc, halted, trap); end
    for (int i = 0; i < 8; i++) begin
      pc_next = 100 + i; tick();
      total++; if (trap !== 1'b0 || pc !== 32'(100 + i)) begin bad++; $display("FAIL counter_disabled pc=%0d trap=%b want=%0d 0", pc, trap, 100 + i); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 59) == 0);
      stall        = ($urandom_range(0, 4) == 0);
      halt         = ($urandom_range(0, 9) == 0);
      resume       = ($urandom_range(0, 2) == 0);
      quantum_load = ($urandom_range(0, 11) == 0);
      quantum      = 16'($urandom_range(0, 6));
      pc_next      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      tick();
      total++;
      if ({pc, pc_plus1, epc, trap, halted} !== {m_pc, m_pc + 32'd1, m_epc, m_trap, m_halted}) begin
        bad++;
        $display("FAIL random i=%0d got pc=%0h epc=%0h trap=%b halted=%b want pc=%0h epc=%0h trap=%b halted=%b",
                 i, pc, epc, trap, halted, m_pc, m_epc, m_trap, m_halted);
      end
    end
    idle_inputs();
  endtask

  initial begin
    m_pc = 0; m_epc = 0; m_trap = 0; m_halted = 0; m_budget = 0;
    test_reset();
    test_basic();
    test_quantum();
    test_stall();
    test_halt();
    test_halt_expiry();
    test_reset_halted();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program counter register and fetch-sequencing stage sitting directly downstream of the next-PC select mux. It registers the mux's selected address each cycle, exposes the current PC and PC+1 (the mux's sequential input) to the rest of the datapath, and supports pipeline stall and HALT. It also enforces the OS time quantum: when a user process's instruction budget expires, it saves the return address and forces entry to the OS handler at word 524.

## Interface
- WIDTH, 32, address width of all PC-related buses
- OS_ENTRY, 524, OS handler address forced on quantum expiry
- QW, 16, quantum counter width

- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; polarity and synchronicity fixed
- pc_next  in  WIDTH  selected next address from the PC select mux
- stall  in  1  freeze PC and quantum counter this cycle
- halt  in  1  current instruction is HALT
- resume  in  1  leave HALTED state
- quantum_load  in  1  load quantum counter from `quantum`
- quantum  in  QW  instruction budget; 0 disables preemption
- pc  out  WIDTH  current instruction address
- pc_plus1  out  WIDTH  pc + 1, feeds the mux sequential input
- epc  out  WIDTH  saved return address from the last preemption
- trap  out  1  one-cycle pulse: pc has just been forced to OS_ENTRY
- halted  out  1  high while in HALTED

## Operation
- States: RUN, HALTED; encoded in 1 bit.
- Reset values: pc=0, epc=0, trap=0, halted=0, counter=0, state=RUN.
- Arithmetic: pc_plus1 is combinational pc+1 modulo 2^WIDTH, so 0xFFFFFFFF wraps to 0.
- Quantum counter:
  - quantum_load writes the counter regardless of state or stall.
  - quantum_load has priority over any decrement in the same cycle.
  - counter==0 means preemption is disabled and the counter never decrements.
- RUN, priority highest first:
  1. stall: pc, epc, and counter hold; trap=0.
  2. halt: go to HALTED; pc holds (stays on the HALT instruction); counter holds.
  3. counter==1 (the budget expires on this retirement): epc<=pc_next, pc<=OS_ENTRY, counter<=0, trap<=1.
  4. Otherwise: pc<=pc_next; counter decrements if nonzero.
- HALTED:
  - halted=1; pc, epc, and counter hold; stall and halt are ignored.
  - resume: go to RUN with pc unchanged; normal sequencing resumes on the following cycle.
- trap is registered: it is high for exactly the one cycle in which pc==OS_ENTRY was first loaded by preemption, and low otherwise.
  - A normal pc_next that happens to equal OS_ENTRY does not raise trap.
- Simultaneous halt and expiry: halt wins; the counter keeps value 1 and expires on the first retirement after resume.
- Reset mid-operation (including in HALTED or during a trap cycle): all state returns to reset values on that edge.

## Timing
- Latency: pc_next is sampled at edge N and visible on pc after edge N. One cycle, no bypass.
- pc_plus1 and halted are combinational from registered state; there is no input-to-output combinational path.
- epc and pc update on the same edge as a preemption.
- quantum_load followed by k unstalled, non-halt retirements with k==quantum produces trap after the k-th retirement.

## Structure
- Shared package holds:
  - OS_ENTRY default (524), shared with the PC select mux.
  - State encodings ST_RUN and ST_HALTED.
  - WIDTH and QW defaults.
- Sub-module `quantum_counter`:
  - Inputs: load, value, dec_en.
  - Outputs: count, expire (count==1).
  - Instantiated once.
- Top level holds the pc/epc/trap registers and the state machine.

## Test plan
- Reset, then pc_next=5 for one cycle: pc=5 and pc_plus1=6 one cycle later. Then pc_next=0xFFFFFFFF: pc_plus1=0.
- quantum_load with quantum=3, pc_next sequence 10,11,12: pc goes 10, 11, then 524 with trap=1 for one cycle and epc=12. Next cycle trap=0.
- stall held 4 cycles mid-quantum: pc and counter are frozen. Preemption occurs exactly 4 cycles later than in the unstalled run.
- halt asserted while pc=40: halted=1 and pc stays 40 regardless of pc_next. resume: pc follows pc_next from the next cycle.
- halt and expiry in the same cycle: state goes to HALTED with no trap. After resume, the first retirement traps with epc = that cycle's pc_next.
- reset pulsed while HALTED with epc=77: pc=0, epc=0, halted=0, and the counter is disabled.
